// File: rtl/pwm_pkg.sv
// Shared PWM definitions: capture FSM state encoding, generator frame length
// and the duty-value width used by both the generator and the capture side.
package pwm_pkg;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pwm_state_e;

    localparam int PWM_FRAME = 256;
    localparam int DUTY_W    = 8;

endpackage

// File: rtl/pwm_capture_if.sv
// Measurement bundle produced by pwm_capture; state is a debug view of the FSM.
interface pwm_capture_if import pwm_pkg::*; #(
    parameter int CNT_W = 16
);
    // meas_vld and duty_vld are valid-only one-cycle pulses with no ready:
    // the consumer must take high_time/period (or duty) in the pulse cycle;
    // the values are then held until the next pulse.
    logic [CNT_W-1:0]  high_time;
    logic [CNT_W-1:0]  period;
    logic              meas_vld;
    logic              stuck;
    logic              stuck_lvl;
    logic [DUTY_W-1:0] duty;
    logic              duty_vld;
    pwm_state_e        state;

    modport master (
        output high_time, period, meas_vld, stuck, stuck_lvl, duty, duty_vld, state
    );

    modport slave (
        input high_time, period, meas_vld, stuck, stuck_lvl, duty, duty_vld, state
    );

endinterface

// File: rtl/pwm_div_u8.sv
// Sequential restoring divider: quot = floor(num*256/den), one quotient bit
// per cycle; the first bit is resolved in the start cycle, done pulses 8 cycles later.
module pwm_div_u8 import pwm_pkg::*; #(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  num,
    input  logic [CNT_W-1:0]  den,
    output logic              busy,
    output logic              done,
    output logic [DUTY_W-1:0] quot
);

    logic [CNT_W-1:0] rem_q;
    logic [CNT_W-1:0] den_q;
    logic [CNT_W-1:0] rem_sel;
    logic [CNT_W-1:0] den_sel;
    logic [CNT_W-1:0] rem_step;
    logic [CNT_W:0]   trial;
    logic [2:0]       cnt_q;
    logic             sat_q;
    logic             take;

    // Remainder stays below den, so the shifted trial fits in CNT_W+1 bits.
    always_comb begin
        rem_sel  = busy ? rem_q : num;
        den_sel  = busy ? den_q : den;
        trial    = {rem_sel, 1'b0};
        take     = (trial >= {1'b0, den_sel});
        rem_step = take ? CNT_W'(trial - {1'b0, den_sel}) : trial[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            rem_q <= '0;
            den_q <= '0;
            cnt_q <= '0;
            sat_q <= 1'b0;
            quot  <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                busy <= 1'b0;
            end else if (!busy) begin
                if (start) begin
                    busy  <= 1'b1;
                    den_q <= den;
                    rem_q <= rem_step;
                    cnt_q <= 3'd7;
                    // A ratio of one or more (saturated counters, den=0) clamps to full scale.
                    sat_q <= (num >= den);
                    quot  <= (num >= den) ? '1 : {{(DUTY_W-1){1'b0}}, take};
                end
            end else begin
                rem_q <= rem_step;
                cnt_q <= cnt_q - 3'd1;
                if (!sat_q) begin
                    quot <= {quot[DUTY_W-2:0], take};
                end
                if (cnt_q == 3'd1) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// PWM receiver: measures high time and rise-to-rise period of pwm_in in clk cycles.
// Optional duty conversion enabled by defining PWM_CAP_DUTY_EN.
module pwm_capture import pwm_pkg::*; #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pwm_in,
    pwm_capture_if.master cap
);

    localparam logic [CNT_W-1:0] TO_M1 = CNT_W'(TIMEOUT - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic s1, s2, s3;
    logic rise, fall, any_edge, timeout;
    pwm_state_e state_q, state_d;
    logic [CNT_W-1:0] hi_cnt, per_cnt, hi_d, per_d, idle_cnt;
    logic [CNT_W-1:0] high_time_q, period_q;
    logic load, meas_vld_q, stuck_q, stuck_lvl_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= pwm_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise     = s2 & ~s3;
    assign fall     = ~s2 & s3;
    assign any_edge = rise | fall;
    // Fires in the cycle idle_cnt steps onto TIMEOUT; a coincident edge wins.
    assign timeout  = ~any_edge & (idle_cnt == TO_M1);

    always_comb begin
        state_d = state_q;
        hi_d    = hi_cnt;
        per_d   = per_cnt;
        load    = 1'b0;
        unique case (state_q)
            SYNC: begin
                if (rise) begin
                    hi_d    = CNT_W'(1);
                    per_d   = CNT_W'(1);
                    state_d = HIGH;
                end
            end
            HIGH: begin
                per_d = sat_inc(per_cnt);
                if (fall) begin
                    state_d = LOW;
                end else begin
                    hi_d = sat_inc(hi_cnt);
                end
            end
            LOW: begin
                if (rise) begin
                    load    = 1'b1;
                    hi_d    = CNT_W'(1);
                    per_d   = CNT_W'(1);
                    state_d = HIGH;
                end else begin
                    per_d = sat_inc(per_cnt);
                end
            end
            default: state_d = SYNC;
        endcase
        if (timeout) begin
            state_d = SYNC;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= SYNC;
            hi_cnt      <= '0;
            per_cnt     <= '0;
            idle_cnt    <= '0;
            high_time_q <= '0;
            period_q    <= '0;
            meas_vld_q  <= 1'b0;
            stuck_q     <= 1'b0;
            stuck_lvl_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hi_cnt     <= hi_d;
            per_cnt    <= per_d;
            idle_cnt   <= any_edge ? '0 : sat_inc(idle_cnt);
            meas_vld_q <= load;
            if (load) begin
                high_time_q <= hi_cnt;
                period_q    <= per_cnt;
                stuck_q     <= 1'b0;
                stuck_lvl_q <= 1'b0;
            end
            if (timeout) begin
                stuck_q     <= 1'b1;
                stuck_lvl_q <= s2;
            end
        end
    end

    assign cap.high_time = high_time_q;
    assign cap.period    = period_q;
    assign cap.meas_vld  = meas_vld_q;
    assign cap.stuck     = stuck_q;
    assign cap.stuck_lvl = stuck_lvl_q;
    assign cap.state     = state_q;

`ifdef PWM_CAP_DUTY_EN
    logic              div_busy, div_done;
    logic [DUTY_W-1:0] div_quot;
    logic [DUTY_W-1:0] duty_q;
    logic              duty_vld_q;

    pwm_div_u8 #(.CNT_W(CNT_W)) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .start (meas_vld_q & ~div_busy),
        .abort (timeout),
        .num   (high_time_q),
        .den   (period_q),
        .busy  (div_busy),
        .done  (div_done),
        .quot  (div_quot)
    );

    // A stuck line reports full or zero duty and pre-empts any divide in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            duty_q     <= '0;
            duty_vld_q <= 1'b0;
        end else begin
            duty_vld_q <= 1'b0;
            if (timeout) begin
                duty_q     <= s2 ? '1 : '0;
                duty_vld_q <= 1'b1;
            end else if (div_done) begin
                duty_q     <= div_quot;
                duty_vld_q <= 1'b1;
            end
        end
    end

    assign cap.duty     = duty_q;
    assign cap.duty_vld = duty_vld_q;
`else
    assign cap.duty     = '0;
    assign cap.duty_vld = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: table-driven PWM patterns plus hand-written stuck,
// reset and edge-versus-timeout sequences, checked through an expected queue.
module tb_pwm_capture;
    import pwm_pkg::*;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 300;
    localparam int EW      = 2 * CNT_W + 8;

    logic clk = 1'b0;
    logic rst_n;
    logic pwm_in;

    pwm_capture_if #(.CNT_W(CNT_W)) cap ();

    pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .pwm_in (pwm_in),
        .cap    (cap)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hi;
        int lo;
        int n;
        int ht;
        int per;
        int duty;
    } vec_t;

    typedef struct {
        int         cyc;
        logic [7:0] duty;
    } hist_t;

    int total  = 0;
    int passed = 0;
    int cyc    = 0;
    logic [EW-1:0] exp_q[$];
    hist_t hist[$];
    logic [EW-1:0] mon_e;
    int last_meas_cyc, last_duty_cyc, duty_cnt, meas_cnt;
    bit last_meas_ok, last_duty_ok, mon_found;
    logic [7:0] mon_duty;
    vec_t vecs[10];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic flush();
        exp_q.delete();
        hist.delete();
        last_meas_ok = 1'b0;
        last_duty_ok = 1'b0;
        duty_cnt     = 0;
        meas_cnt     = 0;
    endtask

    task automatic push_exp(input int ht, input int per, input int duty);
        exp_q.push_back({CNT_W'(ht), CNT_W'(per), 8'(duty)});
    endtask

    task automatic check_reset_state();
        chk("rst_high_time", 32'(cap.high_time), 32'd0);
        chk("rst_period",    32'(cap.period),    32'd0);
        chk("rst_meas_vld",  32'(cap.meas_vld),  32'd0);
        chk("rst_stuck",     32'(cap.stuck),     32'd0);
        chk("rst_stuck_lvl", 32'(cap.stuck_lvl), 32'd0);
        chk("rst_duty",      32'(cap.duty),      32'd0);
        chk("rst_duty_vld",  32'(cap.duty_vld),  32'd0);
        chk("rst_state",     32'(cap.state),     32'(SYNC));
    endtask

    // One-cycle reset pulse, then the outputs must read all-zero.
    task automatic do_reset();
        rst_n = 1'b0;
        tick(1);
        check_reset_state();
        rst_n = 1'b1;
        flush();
    endtask

    task automatic drive_periods(input int hi, input int lo, input int n);
        for (int k = 0; k < n; k++) begin
            pwm_in = 1'b1;
            tick(hi);
            pwm_in = 1'b0;
            tick(lo);
        end
        pwm_in = 1'b1;
        tick(15);
        chk("meas_all_seen", 32'(exp_q.size()), 32'd0);
    endtask

    // Measurement scoreboard: every meas_vld pops one expected record.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && cap.meas_vld === 1'b1) begin
            chk("meas_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("high_time", 32'(cap.high_time), 32'(mon_e[EW-1 -: CNT_W]));
                chk("period",    32'(cap.period),    32'(mon_e[8 +: CNT_W]));
                if (last_meas_ok)
                    chk("meas_spacing", 32'(cyc - last_meas_cyc), 32'(mon_e[8 +: CNT_W]));
                last_meas_cyc = cyc;
                last_meas_ok  = 1'b1;
                meas_cnt++;
                hist.push_back('{cyc: cyc, duty: mon_e[7:0]});
`ifndef PWM_CAP_DUTY_EN
                chk("duty_tied_off", 32'({cap.duty, cap.duty_vld}), 32'd0);
`endif
            end
        end
    end

`ifdef PWM_CAP_DUTY_EN
    // Divide results must land exactly 9 cycles after an accepted measurement.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && cap.duty_vld === 1'b1) begin
            mon_found = 1'b0;
            mon_duty  = '0;
            foreach (hist[i]) begin
                if (hist[i].cyc == cyc - 9) begin
                    mon_found = 1'b1;
                    mon_duty  = hist[i].duty;
                end
            end
            if (mon_found) begin
                chk("duty", 32'(cap.duty), 32'(mon_duty));
                if (last_duty_ok)
                    chk("duty_spacing_ge9", 32'((cyc - last_duty_cyc) >= 9), 32'd1);
                last_duty_cyc = cyc;
                last_duty_ok  = 1'b1;
                duty_cnt++;
            end else if (cap.stuck !== 1'b1) begin
                chk("duty_has_meas", 32'(mon_found), 32'd1);
            end
        end
    end
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, got %0d checks, expected completion", total);
        $display("%0d/%0d checks passed", passed, total + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int hi, lo;
        vecs[0] = '{hi: 10,  lo: 30,  n: 4, ht: 10,  per: 40,  duty: 64};
        vecs[1] = '{hi: 65,  lo: PWM_FRAME - 65, n: 3, ht: 65, per: PWM_FRAME, duty: 65};
        vecs[2] = '{hi: 2,   lo: 3,   n: 8, ht: 2,   per: 5,   duty: 102};
        vecs[3] = '{hi: 1,   lo: 1,   n: 6, ht: 1,   per: 2,   duty: 128};
        vecs[4] = '{hi: 128, lo: 128, n: 2, ht: 128, per: 256, duty: 128};
        vecs[5] = '{hi: 3,   lo: 250, n: 2, ht: 3,   per: 253, duty: 3};
        for (int i = 6; i < 10; i++) begin
            hi = int'($urandom_range(1, 40));
            lo = int'($urandom_range(1, 60));
            vecs[i] = '{hi: hi, lo: lo, n: 3, ht: hi, per: hi + lo, duty: (hi * 256) / (hi + lo)};
        end

        pwm_in = 1'b0;
        rst_n  = 1'b0;
        tick(2);
        do_reset();

        for (int i = 0; i < 10; i++) begin
            do_reset();
            for (int k = 0; k < vecs[i].n; k++)
                push_exp(vecs[i].ht, vecs[i].per, vecs[i].duty);
            drive_periods(vecs[i].hi, vecs[i].lo, vecs[i].n);
            chk("meas_count", 32'(meas_cnt), 32'(vecs[i].n));
`ifdef PWM_CAP_DUTY_EN
            chk("duty_seen", 32'(duty_cnt > 0), 32'd1);
            if (vecs[i].per < 9)
                chk("div_dropped_overlap", 32'(duty_cnt < meas_cnt), 32'd1);
`endif
        end

        // Line stuck high: one rise from SYNC, then no further edge.
        do_reset();
        pwm_in = 1'b1;
        tick(TIMEOUT + 2);
        chk("stuck_early", 32'(cap.stuck), 32'd0);
        tick(1);
        chk("stuck_set", 32'(cap.stuck), 32'd1);
        chk("stuck_lvl", 32'(cap.stuck_lvl), 32'd1);
        chk("stuck_state", 32'(cap.state), 32'(SYNC));
`ifdef PWM_CAP_DUTY_EN
        chk("stuck_duty", 32'(cap.duty), 32'd255);
        chk("stuck_duty_vld", 32'(cap.duty_vld), 32'd1);
`else
        chk("stuck_duty", 32'({cap.duty, cap.duty_vld}), 32'd0);
`endif
        tick(10);
        chk("stuck_held", 32'(cap.stuck), 32'd1);
        chk("stuck_duty_vld_pulse", 32'(cap.duty_vld), 32'd0);
        chk("stuck_keeps_period", 32'(cap.period), 32'd0);

        // Resume: stuck clears only with the first reported period.
        pwm_in = 1'b0;
        tick(30);
        push_exp(10, 40, 64);
        push_exp(10, 40, 64);
        pwm_in = 1'b1;
        tick(10);
        pwm_in = 1'b0;
        tick(30);
        pwm_in = 1'b1;
        tick(2);
        chk("stuck_before_report", 32'(cap.stuck), 32'd1);
        tick(1);
        chk("report_after_stuck", 32'(cap.meas_vld), 32'd1);
        chk("stuck_cleared", 32'(cap.stuck), 32'd0);
        tick(7);
        pwm_in = 1'b0;
        tick(30);
        pwm_in = 1'b1;
        tick(6);
        chk("resume_all_seen", 32'(exp_q.size()), 32'd0);
        chk("mid_high_state", 32'(cap.state), 32'(HIGH));

        // Reset mid-HIGH with a divide in flight; the line stays high across it.
        do_reset();
        push_exp(7, 37, 48);
        push_exp(10, 40, 64);
        tick(7);
        pwm_in = 1'b0;
        tick(30);
        pwm_in = 1'b1;
        tick(10);
        pwm_in = 1'b0;
        tick(30);
        pwm_in = 1'b1;
        tick(15);
        chk("post_reset_all_seen", 32'(exp_q.size()), 32'd0);

        // Fall detected in the very cycle the idle counter reaches TIMEOUT.
        pwm_in = 1'b0;
        do_reset();
        push_exp(10, 40, 64);
        push_exp(TIMEOUT, TIMEOUT + 30, (TIMEOUT * 256) / (TIMEOUT + 30));
        pwm_in = 1'b1;
        tick(10);
        pwm_in = 1'b0;
        tick(30);
        pwm_in = 1'b1;
        tick(TIMEOUT);
        pwm_in = 1'b0;
        tick(3);
        chk("coincident_no_stuck", 32'(cap.stuck), 32'd0);
        chk("coincident_state", 32'(cap.state), 32'(LOW));
        tick(27);
        pwm_in = 1'b1;
        tick(15);
        chk("coincident_all_seen", 32'(exp_q.size()), 32'd0);
        chk("coincident_stuck_end", 32'(cap.stuck), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
